// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer between the UART receiver and
// the APB UART register block. First-word-fall-through: while not empty the
// head character and its framing-error flag are presented on o_rd_data/o_rd_err.
//
// Optional feature macro: UART_RX_FIFO_THRESH_EN
//   defined   -> o_thresh_irq = (count >= THRESH), registered
//   undefined -> o_thresh_irq tied to 0, THRESH ignored
//
// Ports:
//   i_clk          system clock (PCLK domain)
//   i_rst          synchronous reset, active-high
//   i_wr_valid     push strobe (receiver done pulse)
//   i_wr_data      received character
//   i_wr_err       framing error for this character
//   i_rd_en        pop strobe (RX_DATA read)
//   i_flush        discard all entries
//   i_clr_overrun  clear the sticky overrun flag
//   o_rd_data      head character, valid when o_empty=0
//   o_rd_err       error flag stored with the head character
//   o_empty        count == 0
//   o_full         count == DEPTH
//   o_count        number of entries, 0..DEPTH
//   o_overrun      sticky: a push was dropped because the FIFO was full
//   o_thresh_irq   level interrupt: count >= THRESH (feature builds only)
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned THRESH    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_wr_err,
  input  logic                 i_rd_en,
  input  logic                 i_flush,
  input  logic                 i_clr_overrun,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_rd_err,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_overrun,
  output logic                 o_thresh_irq
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = DATA_BITS + 1;

  // Elaboration-time parameter sanity checks
  if ((32'd1 << ADDR_W) != DEPTH || DEPTH < 2) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
  end

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_empty;
  logic               r_full;
  logic               r_overrun;

  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic [ADDR_W-1:0]  w_rd_ptr_nxt;
  logic [ENTRY_W-1:0] w_head;

  // Push/pop qualification and next pointer/count; flush overrides both
  always_comb begin
    w_pop        = i_rd_en & ~r_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    w_push       = i_wr_valid & (~r_full | w_pop);
    // Flush discards the push, so a flushed overflow is not an overrun
    w_drop       = i_wr_valid & r_full & ~w_pop & ~i_flush;
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (i_flush) begin
      w_count_nxt  = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state; empty/full are registered from the next count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_empty   <= (w_count_nxt == '0);
      r_full    <= (w_count_nxt == CNT_W'(DEPTH));
      // Set beats clear when both happen in one cycle
      if (w_drop)             r_overrun <= 1'b1;
      else if (i_clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Storage array; never cleared
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= {i_wr_err, i_wr_data};
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign o_rd_data = w_head[DATA_BITS-1:0];
  assign o_rd_err  = w_head[DATA_BITS];
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

`ifdef UART_RX_FIFO_THRESH_EN
  logic r_thresh_irq;

  // Level interrupt tracks the count that is current after each edge
  always_ff @(posedge i_clk) begin
    if (i_rst) r_thresh_irq <= 1'b0;
    else       r_thresh_irq <= (w_count_nxt >= CNT_W'(THRESH));
  end

  assign o_thresh_irq = r_thresh_irq;
`else
  assign o_thresh_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (DEPTH=16, THRESH=8).
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_err;
  logic       rd_en;
  logic       flush;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       thresh_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb_q[$];
  int         m_cnt = 0;

  uart_rx_fifo #(
    .DATA_BITS(8), .DEPTH(16), .ADDR_W(4), .THRESH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .i_wr_err(wr_err), .i_rd_en(rd_en), .i_flush(flush),
    .i_clr_overrun(clr_overrun), .o_rd_data(rd_data), .o_rd_err(rd_err),
    .o_empty(empty), .o_full(full), .o_count(count), .o_overrun(overrun),
    .o_thresh_irq(thresh_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit thr(input bit b);
    return THR_EN & b;
  endfunction

  task automatic chk_status(input string name, input bit e_empty, input bit e_full,
                            input int unsigned e_count, input bit e_ovr, input bit e_thr);
    check({name, ".empty"},   32'(empty),      32'(e_empty));
    check({name, ".full"},    32'(full),       32'(e_full));
    check({name, ".count"},   32'(count),      e_count);
    check({name, ".overrun"}, 32'(overrun),    32'(e_ovr));
    check({name, ".thresh"},  32'(thresh_irq), 32'(e_thr));
  endtask

  // One clock of stimulus; expected pops are queued as the push is issued
  task automatic cyc(input bit wv, input logic [7:0] d, input bit e,
                     input bit re, input bit fl, input bit clr);
    bit pop;
    bit push;
    wr_valid = wv; wr_data = d; wr_err = e;
    rd_en = re; flush = fl; clr_overrun = clr;
    pop  = re && (m_cnt > 0);
    push = wv && ((m_cnt < 16) || pop);
    if (fl) begin
      sb_q.delete();
      m_cnt = 0;
    end else begin
      if (push) sb_q.push_back({e, d});
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_data = 8'h00; wr_err = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every effective pop must deliver the oldest queued character
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got 0x%0h, expected no pop", {rd_err, rd_data});
      end else begin
        check("sb_head", 32'({rd_err, rd_data}), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_err = 1'b0;
    rd_en = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single push then pop
    push(8'hA5);
    chk_status("t1_push", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    check("t1_rd_data", 32'(rd_data), 32'h A5);
    check("t1_rd_err",  32'(rd_err),  32'h0);
    pop();
    chk_status("t1_pop", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // 2: fill, overflow, drain in order, clear overrun
    for (int i = 0; i < 16; i++) push(8'(i));
    chk_status("t2_full", 1'b0, 1'b1, 16, 1'b0, thr(1'b1));
    push(8'hFF);
    chk_status("t2_ovr", 1'b0, 1'b1, 16, 1'b1, thr(1'b1));
    for (int i = 0; i < 16; i++) pop();
    chk_status("t2_drain", 1'b1, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_status("t2_clr", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // 3: push+pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_status("t3_pushpop", 1'b0, 1'b1, 16, 1'b0, thr(1'b1));
    for (int i = 0; i < 15; i++) pop();
    check("t3_last", 32'(rd_data), 32'h55);
    check("t3_last_cnt", 32'(count), 32'd1);
    pop();
    chk_status("t3_drain", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // 4: push+pop while empty, error flag carried
    cyc(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_status("t4_push", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    check("t4_rd_data", 32'(rd_data), 32'h3C);
    check("t4_rd_err",  32'(rd_err),  32'h1);
    pop();

    // 5: flush with push, overrun persistence, clear priority
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk_status("t5_five", 1'b0, 1'b0, 5, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("t5_flush", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    push(8'hEE);
    chk_status("t5_ovr", 1'b0, 1'b1, 16, 1'b1, thr(1'b1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_status("t5_flush_ovr", 1'b1, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_status("t5_clr", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_status("t5_set_wins", 1'b0, 1'b1, 16, 1'b1, thr(1'b1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_status("t5_flush_clr", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // 6: threshold interrupt around THRESH=8
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    chk_status("t6_seven", 1'b0, 1'b0, 7, 1'b0, 1'b0);
    push(8'hC7);
    chk_status("t6_eight", 1'b0, 1'b0, 8, 1'b0, thr(1'b1));
    pop();
    chk_status("t6_pop", 1'b0, 1'b0, 7, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) pop();
    chk_status("t6_drain", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Spurious pop on empty must change nothing
    pop();
    chk_status("empty_pop", 1'b1, 1'b0, 0, 1'b0, 1'b0);

    check("sb_left", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
